cla8b_result_display: RTL and testbench

- Output-side companion to the 8-bit CLA operand controller; reads the adder result {cout, sum[7:0]} (0..511).
- Converts the result sequentially to 3-digit BCD with a shift-add-3 (double-dabble) FSM.
- Drives a 4-digit multiplexed, active-low 7-segment display on the board.

---
 rtl/cla8b_result_display.sv | 192 +++++++++++++++++++
 tb/tb_cla8b_result_display.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cla8b_result_display.sv
// Converts the CLA result {cout, sum} to 3-digit BCD with a double-dabble FSM and scans it onto a
// 4-digit active-low 7-segment display. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module cla8b_result_display #(
    parameter int REFRESH_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sum,
    input  logic       cout,
    output logic       busy,
    output logic [11:0] bcd_out,
    output logic [6:0] seg,
    output logic [3:0] an
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [20:0]             sreg_q, sreg_d;
    logic [3:0]              iter_q, iter_d;
    logic [8:0]              last_q, last_d;
    logic                    busy_q, busy_d;
    logic [11:0]             bcd_q, bcd_d;
    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
    logic [6:0]              seg_q, seg_d;
    logic [3:0]              an_q, an_d;

    logic [8:0]  value_s;
    logic [20:0] adj_s;
    logic [1:0]  sel_s;
    logic        blank_hund_s;
    logic        blank_tens_s;

    function automatic logic [3:0] add3(input logic [3:0] n);
        if (n >= 4'd5) begin
            return n + 4'd3;
        end else begin
            return n;
        end
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    assign value_s = {cout, sum};
    assign adj_s   = {add3(sreg_q[20:17]), add3(sreg_q[16:13]), add3(sreg_q[12:9]), sreg_q[8:0]};
    assign sel_s   = cnt_q[REFRESH_BITS-1 -: 2];

    // State register: every flop in the block, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= 21'd0;
            iter_q  <= 4'd0;
            last_q  <= 9'd0;
            busy_q  <= 1'b0;
            bcd_q   <= 12'h000;
            cnt_q   <= '0;
            seg_q   <= 7'h7F;
            an_q    <= 4'hF;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            iter_q  <= iter_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    // Next-state logic of the conversion FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (value_s != last_q) begin
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                if (iter_q == 4'd8) begin
                    state_d = DONE;
                end else begin
                    state_d = CONV;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Conversion datapath: capture, nine add-3/shift steps, then publish the BCD field.
    always_comb begin
        sreg_d = sreg_q;
        iter_d = iter_q;
        last_d = last_q;
        busy_d = busy_q;
        bcd_d  = bcd_q;
        case (state_q)
            IDLE: begin
                if (value_s != last_q) begin
                    sreg_d = {12'h000, value_s};
                    last_d = value_s;
                    iter_d = 4'd0;
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            CONV: begin
                sreg_d = {adj_s[19:0], 1'b0};
                iter_d = iter_q + 4'd1;
            end
            DONE: begin
                bcd_d  = sreg_q[20:9];
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_hund_s = (bcd_q[11:8] == 4'd0);
    assign blank_tens_s = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
`else
    assign blank_hund_s = 1'b0;
    assign blank_tens_s = 1'b0;
`endif

    // Display scan: free-running counter picks a digit; drive is registered a cycle behind sel.
    always_comb begin
        cnt_d = cnt_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
        seg_d = 7'h7F;
        an_d  = 4'hF;
        case (sel_s)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = seg7(bcd_q[3:0]);
            end
            2'd1: begin
                if (blank_tens_s) begin
                    an_d = 4'b1111;
                end else begin
                    an_d  = 4'b1101;
                    seg_d = seg7(bcd_q[7:4]);
                end
            end
            2'd2: begin
                if (blank_hund_s) begin
                    an_d = 4'b1111;
                end else begin
                    an_d  = 4'b1011;
                    seg_d = seg7(bcd_q[11:8]);
                end
            end
            default: begin
                an_d  = 4'b1111;
                seg_d = 7'h7F;
            end
        endcase
    end

    assign busy    = busy_q;
    assign bcd_out = bcd_q;
    assign seg     = seg_q;
    assign an      = an_q;

endmodule

// File: tb/tb_cla8b_result_display.sv
// Directed bench for cla8b_result_display with a short scan counter (REFRESH_BITS = 4).
module tb_cla8b_result_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sum = 8'd0;
    logic        cout = 1'b0;
    logic        busy;
    logic [11:0] bcd_out;
    logic [6:0]  seg;
    logic [3:0]  an;

    int total = 0;
    int bad = 0;

    cla8b_result_display #(.REFRESH_BITS(4)) dut (
        .clk(clk), .rst(rst), .sum(sum), .cout(cout),
        .busy(busy), .bcd_out(bcd_out), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [8:0] v);
        cout = v[8];
        sum  = v[7:0];
    endtask

    // Counts busy-high samples until busy falls; start is the number already seen.
    task automatic wait_fall(input int start, output int cnt);
        cnt = start;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy === 1'b1) cnt++;
            else if (cnt > 0) return;
        end
        cnt = 999;
    endtask

    task automatic test_reset();
        logic stuck;
        rst = 1'b1;
        apply(9'd0);
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (bcd_out !== 12'h000) begin bad++; $display("FAIL reset_bcd: got %h want 000", bcd_out); end
        total++; if (seg !== 7'h7F) begin bad++; $display("FAIL reset_seg: got %b want 1111111", seg); end
        total++; if (an !== 4'hF) begin bad++; $display("FAIL reset_an: got %b want 1111", an); end
        rst = 1'b0;
        stuck = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy !== 1'b0) stuck = 1'b1;
        end
        total++; if (stuck !== 1'b0) begin bad++; $display("FAIL idle_zero_busy: got busy=1 want 0 for 50 cycles"); end
        total++; if (bcd_out !== 12'h000) begin bad++; $display("FAIL idle_zero_bcd: got %h want 000", bcd_out); end
    endtask

    task automatic test_max();
        int cnt;
        apply(9'd511);
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL max_rise: got %b want 1", busy); end
        wait_fall(1, cnt);
        total++; if (cnt != 10) begin bad++; $display("FAIL max_busy_len: got %0d want 10", cnt); end
        total++; if (bcd_out !== 12'h511) begin bad++; $display("FAIL max_bcd: got %h want 511", bcd_out); end
    endtask

    task automatic test_back_to_back();
        int cnt;
        apply(9'd100);
        wait_fall(0, cnt);
        total++; if (cnt != 10) begin bad++; $display("FAIL b2b_len1: got %0d want 10", cnt); end
        total++; if (bcd_out !== 12'h100) begin bad++; $display("FAIL b2b_bcd1: got %h want 100", bcd_out); end
        apply(9'd99);
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_gap: got busy=%b want 1", busy); end
        wait_fall(1, cnt);
        total++; if (cnt != 10) begin bad++; $display("FAIL b2b_len2: got %0d want 10", cnt); end
        total++; if (bcd_out !== 12'h099) begin bad++; $display("FAIL b2b_bcd2: got %h want 099", bcd_out); end
    endtask

    task automatic test_change_while_busy();
        int cnt;
        apply(9'd200);
        for (int i = 0; i < 4; i++) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL chg_busy4: got %b want 1", busy); end
        apply(9'd37);
        wait_fall(4, cnt);
        total++; if (cnt != 10) begin bad++; $display("FAIL chg_len1: got %0d want 10", cnt); end
        total++; if (bcd_out !== 12'h200) begin bad++; $display("FAIL chg_bcd1: got %h want 200", bcd_out); end
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL chg_restart: got %b want 1", busy); end
        total++; if (bcd_out !== 12'h200) begin bad++; $display("FAIL chg_hold: got %h want 200", bcd_out); end
        wait_fall(1, cnt);
        total++; if (cnt != 10) begin bad++; $display("FAIL chg_len2: got %0d want 10", cnt); end
        total++; if (bcd_out !== 12'h037) begin bad++; $display("FAIL chg_bcd2: got %h want 037", bcd_out); end
    endtask

    task automatic test_values();
        logic [8:0]  vin [4]  = '{9'd255, 9'd1, 9'd9, 9'd10};
        logic [11:0] vexp [4] = '{12'h255, 12'h001, 12'h009, 12'h010};
        int cnt;
        for (int i = 0; i < 4; i++) begin
            apply(vin[i]);
            wait_fall(0, cnt);
            total++; if (cnt != 10) begin bad++; $display("FAIL val_len[%0d]: got %0d want 10", i, cnt); end
            total++; if (bcd_out !== vexp[i]) begin bad++; $display("FAIL val_bcd[%0d]: got %h want %h", i, bcd_out, vexp[i]); end
        end
    endtask

    task automatic test_scan();
        logic [3:0] an_exp [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
        logic [6:0] seg_exp [4] = '{7'b0100100, 7'b0011001, 7'b1000000, 7'h7F};
        int cnt;
        int k;
`ifdef LEADING_ZERO_BLANK_EN
        an_exp[2]  = 4'b1111;
        seg_exp[2] = 7'h7F;
`endif
        apply(9'd42);
        wait_fall(0, cnt);
        total++; if (bcd_out !== 12'h042) begin bad++; $display("FAIL scan_bcd: got %h want 042", bcd_out); end
        k = 0;
        while (k < 40 && an !== 4'b1111) begin tick(); k++; end
        while (k < 80 && an !== 4'b1110) begin tick(); k++; end
        total++;
        if (k >= 80) begin
            bad++; $display("FAIL scan_align: got an=%b want 1110 within 80 cycles", an);
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++; if (an !== an_exp[i/4]) begin bad++; $display("FAIL scan_an[%0d]: got %b want %b", i, an, an_exp[i/4]); end
                total++; if (seg !== seg_exp[i/4]) begin bad++; $display("FAIL scan_seg[%0d]: got %b want %b", i, seg, seg_exp[i/4]); end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        apply(9'd300);
        for (int i = 0; i < 5; i++) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy5: got %b want 1", busy); end
        rst = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        total++; if (bcd_out !== 12'h000) begin bad++; $display("FAIL rmid_bcd: got %h want 000", bcd_out); end
        total++; if (seg !== 7'h7F) begin bad++; $display("FAIL rmid_seg: got %b want 1111111", seg); end
        total++; if (an !== 4'hF) begin bad++; $display("FAIL rmid_an: got %b want 1111", an); end
        rst = 1'b0;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_restart: got %b want 1", busy); end
        wait_fall(1, cnt);
        total++; if (cnt != 10) begin bad++; $display("FAIL rmid_len: got %0d want 10", cnt); end
        total++; if (bcd_out !== 12'h300) begin bad++; $display("FAIL rmid_bcd2: got %h want 300", bcd_out); end
    endtask

    initial begin
        test_reset();
        test_max();
        test_back_to_back();
        test_change_while_busy();
        test_values();
        test_scan();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
